// File: rtl/echo_delay_if.sv
// ADC-side handshake and processed-sample output of the echo stage, bundled as one bus.
// adc_start_tx asks the ADC for a sample. The ADC raises adc_data_rdy with adc_data valid.
// The sample is taken on the synchronised falling edge of adc_data_rdy.
// out_valid is a one-cycle strobe: out_sample is new in that cycle, and there is no backpressure.
interface echo_delay_if;
    logic       adc_data_rdy;
    logic [7:0] adc_data;
    logic       adc_start_tx;
    logic [7:0] out_sample;
    logic       out_valid;

    modport slave (
        input  adc_data_rdy,
        input  adc_data,
        output adc_start_tx,
        output out_sample,
        output out_valid
    );

    modport master (
        output adc_data_rdy,
        output adc_data,
        input  adc_start_tx,
        input  out_sample,
        input  out_valid
    );
endinterface

// File: rtl/echo_delay.sv
// Feedback echo on 8-bit offset-binary ADC samples, using a single-port RAM ring buffer.
// The output is y = sat8(s + (y[n-D]*g)>>>3). Each sample passes through READ, CALC and WRITE.
module echo_delay #(
    parameter int ADDR_W = 10,
    parameter int SYNC_N = 2
) (
    input  logic              clk,
    input  logic              reset,
    echo_delay_if.slave       bus,
    input  logic [ADDR_W-1:0] delay_len,
    input  logic [3:0]        gain,
    input  logic              bypass,
    output logic              busy,
    output logic [2:0]        dbg_state
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        ST_ARM       = 3'd0,
        ST_WAIT_FALL = 3'd1,
        ST_READ      = 3'd2,
        ST_CALC      = 3'd3,
        ST_WRITE     = 3'd4
    } state_t;

    state_t            r_state, w_next;
    logic [SYNC_N-1:0] r_sync;
    logic              r_rdy_d;
    logic              w_rdy_s;
    logic              w_capture;
    logic              r_start_tx;

    logic [7:0]        r_x;
    logic [ADDR_W-1:0] r_d_len;
    logic [3:0]        r_g;
    logic              r_byp;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_fill;
    logic [7:0]        r_out_sample;
    logic [7:0]        r_w;

    logic [7:0]        r_mem [0:DEPTH-1];
    logic [7:0]        r_rd_data;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [ADDR_W-1:0] w_addr;

    logic [7:0]        w_s;
    logic              w_use;
    logic [7:0]        w_d;
    logic signed [11:0] w_p;
    logic [9:0]        w_e;
    logic [9:0]        w_sum;
    logic [7:0]        w_y;

    assign w_rdy_s   = r_sync[SYNC_N-1];
    assign w_capture = (r_state == ST_WAIT_FALL) && !w_rdy_s && r_rdy_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync  <= '0;
            r_rdy_d <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_N-2:0], bus.adc_data_rdy};
            r_rdy_d <= w_rdy_s;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_ARM:       if (w_rdy_s) w_next = ST_WAIT_FALL;
            ST_WAIT_FALL: if (w_capture) w_next = ST_READ;
            ST_READ:      w_next = ST_CALC;
            ST_CALC:      w_next = ST_WRITE;
            ST_WRITE:     w_next = ST_ARM;
            default:      w_next = ST_ARM;
        endcase
    end

    // start_tx is registered from next state so it is low during reset and glitch-free
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_ARM;
            r_start_tx <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_start_tx <= (w_next == ST_ARM) || (w_next == ST_WAIT_FALL);
        end
    end

    assign w_rd_addr = r_wr_ptr - r_d_len;
    assign w_addr    = (r_state == ST_WRITE) ? r_wr_ptr : w_rd_addr;

    always_ff @(posedge clk) begin
        if (r_state == ST_WRITE) begin
            r_mem[w_addr] <= r_w;
        end else if (r_state == ST_READ) begin
            r_rd_data <= r_mem[w_addr];
        end
    end

    // Stale RAM words are masked until the buffer has been filled past the delay
    assign w_s     = {~r_x[7], r_x[6:0]};
    assign w_use   = (r_d_len != '0) && (r_fill >= r_d_len);
    assign w_d     = w_use ? r_rd_data : 8'd0;
    assign w_p     = {{4{w_d[7]}}, w_d} * {8'd0, r_g};
    assign w_e     = 10'(w_p >>> 3);
    assign w_sum   = {{2{w_s[7]}}, w_s} + w_e;

    always_comb begin
        w_y = w_sum[7:0];
        if (!w_sum[9] && (w_sum[8:7] != 2'b00)) begin
            w_y = 8'h7F;
        end else if (w_sum[9] && (w_sum[8:7] != 2'b11)) begin
            w_y = 8'h80;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_x          <= 8'd0;
            r_d_len      <= '0;
            r_g          <= 4'd0;
            r_byp        <= 1'b0;
            r_wr_ptr     <= '0;
            r_fill       <= '0;
            r_out_sample <= 8'h80;
            r_w          <= 8'd0;
        end else begin
            if (w_capture) begin
                r_x     <= bus.adc_data;
                r_d_len <= delay_len;
                r_g     <= (gain > 4'd8) ? 4'd8 : gain;
                r_byp   <= bypass;
            end
            if (r_state == ST_CALC) begin
                r_out_sample <= r_byp ? r_x : {~w_y[7], w_y[6:0]};
                r_w          <= r_byp ? w_s : w_y;
            end
            if (r_state == ST_WRITE) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
                if (r_fill != '1) r_fill <= r_fill + ADDR_W'(1);
            end
        end
    end

    assign bus.adc_start_tx = r_start_tx;
    assign bus.out_sample   = r_out_sample;
    assign bus.out_valid    = (r_state == ST_WRITE);
    assign busy             = (r_state == ST_READ) || (r_state == ST_CALC) || (r_state == ST_WRITE);
    assign dbg_state        = r_state;
endmodule

// File: tb/tb_echo_delay.sv
// Directed bench for echo_delay: an ADC handshake driver, hand-computed expected samples,
// and a single check task that feeds the final report.
module tb_echo_delay;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [ADDR_W-1:0] delay_len;
  logic [3:0]        gain;
  logic              bypass;
  logic              busy;
  logic [2:0]        dbg_state;

  echo_delay_if bus();

  echo_delay #(.ADDR_W(ADDR_W), .SYNC_N(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .delay_len (delay_len),
    .gain      (gain),
    .bypass    (bypass),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         lat;
  logic       st_at_valid;
  logic       busy_at_valid;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    bus.adc_data_rdy = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (!bus.adc_start_tx && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.adc_start_tx) check({tag, "_start_timeout"}, 32'd0, 32'd1);
  endtask

  // One ADC transfer: raise rdy with data, drop it, then wait (bounded) for the output strobe
  task automatic send(input logic [7:0] v, input logic [7:0] exp, input bit do_chk, input string tag);
    int n;
    bit seen;
    wait_start(tag);
    bus.adc_data = v;
    bus.adc_data_rdy = 1'b1;
    repeat (4) @(negedge clk);
    bus.adc_data_rdy = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 30) begin
      @(negedge clk);
      n++;
      seen = bus.out_valid;
    end
    lat = n;
    st_at_valid = bus.adc_start_tx;
    busy_at_valid = busy;
    if (!seen) check({tag, "_valid_timeout"}, 32'd0, 32'd1);
    else if (do_chk) check(tag, bus.out_sample, exp);
    @(negedge clk);
    bus.adc_data = 8'($urandom_range(0, 255));
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit vld_seen;
    int n;
    bus.adc_data_rdy = 1'b0;
    bus.adc_data = 8'h00;
    delay_len = '0;
    gain = 4'd0;
    bypass = 1'b0;

    // Reset values and a single dry sample
    repeat (2) @(negedge clk);
    check("rst_out_sample", bus.out_sample, 8'h80);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_start_tx", bus.adc_start_tx, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", dbg_state, 3'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("arm_start_tx", bus.adc_start_tx, 1'b1);
    send(8'hC0, 8'hC0, 1'b1, "t1_dry");
    check("t1_latency", lat, 5);
    check("t1_start_tx_busy", st_at_valid, 1'b0);
    check("t1_busy", busy_at_valid, 1'b1);
    check("t1_pulse_width", bus.out_valid, 1'b0);

    // Unity feedback, D=4: impulse repeats every 4 samples
    apply_reset();
    delay_len = 10'd4;
    gain = 4'd8;
    for (int i = 0; i < 12; i++) exp_q.push_back(((i % 4) == 0) ? 8'hFF : 8'h80);
    for (int i = 0; i < 12; i++) send((i == 0) ? 8'hFF : 8'h80, exp_q.pop_front(), 1'b1, "t2_echo4");

    // Saturation at both rails, then half gain
    apply_reset();
    delay_len = 10'd1;
    for (int i = 0; i < 3; i++) send(8'hFF, 8'hFF, 1'b1, "t3_sat_hi");
    apply_reset();
    for (int i = 0; i < 3; i++) send(8'h00, 8'h00, 1'b1, "t3_sat_lo");
    apply_reset();
    gain = 4'd4;
    send(8'hFF, 8'hFF, 1'b1, "t3_g4_a");
    send(8'h80, 8'hBF, 1'b1, "t3_g4_b");

    // Gain above 8 behaves as unity
    apply_reset();
    gain = 4'd15;
    send(8'hC0, 8'hC0, 1'b1, "t3_clamp_a");
    send(8'h80, 8'hC0, 1'b1, "t3_clamp_b");

    // Fill masking: leave garbage in the RAM, then reset (RAM is not cleared)
    apply_reset();
    delay_len = '0;
    gain = 4'd0;
    for (int i = 0; i < 8; i++) send(8'h00, 8'h00, 1'b0, "t4_garbage");
    apply_reset();
    delay_len = 10'd8;
    gain = 4'd8;
    for (int i = 0; i < 8; i++) send(8'h90, 8'h90, 1'b1, "t4_masked");
    send(8'h90, 8'hA0, 1'b1, "t4_first_echo");

    // Bypass passes raw input and still records s for later echoes
    apply_reset();
    bypass = 1'b1;
    delay_len = 10'd2;
    gain = 4'd8;
    send(8'h10, 8'h10, 1'b1, "t5_byp_a");
    send(8'h20, 8'h20, 1'b1, "t5_byp_b");
    send(8'h30, 8'h30, 1'b1, "t5_byp_c");
    bypass = 1'b0;
    send(8'h80, 8'h20, 1'b1, "t5_after_byp");

    // Pointer wrap: echo written near the top of the buffer is read back after wrap to 0
    apply_reset();
    delay_len = '0;
    gain = 4'd0;
    for (int i = 0; i < 1020; i++) send(8'h80, 8'h80, 1'b0, "t_wrap_fill");
    delay_len = 10'd4;
    gain = 4'd8;
    send(8'hFF, 8'hFF, 1'b1, "t_wrap_imp");
    for (int i = 0; i < 3; i++) send(8'h80, 8'h80, 1'b1, "t_wrap_gap");
    send(8'h80, 8'hFF, 1'b1, "t_wrap_echo");

    // Reset during WAIT_FALL and during CALC
    apply_reset();
    delay_len = 10'd1;
    gain = 4'd8;
    send(8'hFF, 8'hFF, 1'b1, "t6_pre_a");
    send(8'hFF, 8'hFF, 1'b1, "t6_pre_b");
    wait_start("t6_wf");
    bus.adc_data = 8'h55;
    bus.adc_data_rdy = 1'b1;
    n = 0;
    while (dbg_state != 3'd1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t6_reach_wait_fall", dbg_state, 3'd1);
    reset = 1'b0;
    #1;
    check("t6_wf_out_sample", bus.out_sample, 8'h80);
    check("t6_wf_start_tx", bus.adc_start_tx, 1'b0);
    check("t6_wf_busy", busy, 1'b0);
    bus.adc_data_rdy = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_start("t6_calc");
    bus.adc_data = 8'h66;
    bus.adc_data_rdy = 1'b1;
    repeat (4) @(negedge clk);
    bus.adc_data_rdy = 1'b0;
    n = 0;
    while (dbg_state != 3'd3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t6_reach_calc", dbg_state, 3'd3);
    reset = 1'b0;
    #1;
    check("t6_calc_out_sample", bus.out_sample, 8'h80);
    check("t6_calc_start_tx", bus.adc_start_tx, 1'b0);
    vld_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      vld_seen |= bus.out_valid;
    end
    reset = 1'b1;
    repeat (10) begin
      @(negedge clk);
      vld_seen |= bus.out_valid;
    end
    check("t6_no_stray_valid", vld_seen, 1'b0);
    send(8'h90, 8'h90, 1'b1, "t6_post_no_echo");
    send(8'h80, 8'h90, 1'b1, "t6_post_echo");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
